regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-port register-file writeback arbiter: round-robin between the pipeline (A)
// and a long-latency unit (B), one registered write per cycle, with stall counters.
module regfile_wb_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  input  logic        clear_stats,
  output logic [15:0] a_stall_cnt,
  output logic [15:0] b_stall_cnt
);

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic        last_grant_q, last_grant_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [15:0] a_stall_q, a_stall_d;
  logic [15:0] b_stall_q, b_stall_d;

  logic a_live, b_live;
  logic a_acc, b_acc;

  // Writes to r0 are not live: they are acknowledged immediately and dropped.
  always_comb begin
    a_live  = a_valid && (a_reg != 5'd0);
    b_live  = b_valid && (b_reg != 5'd0);
    a_ready = 1'b1;
    b_ready = 1'b1;
    if (reset) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end else if (a_live && b_live) begin
      a_ready = (last_grant_q == GRANT_B);
      b_ready = (last_grant_q == GRANT_A);
    end
    a_acc = a_live && a_ready;
    b_acc = b_live && b_ready;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wr_reg_d     = 5'd0;
    wr_data_d    = wr_data_q;
    if (a_acc) begin
      last_grant_d = GRANT_A;
      wr_reg_d     = a_reg;
      wr_data_d    = a_data;
    end else if (b_acc) begin
      last_grant_d = GRANT_B;
      wr_reg_d     = b_reg;
      wr_data_d    = b_data;
    end

    a_stall_d = a_stall_q;
    b_stall_d = b_stall_q;
    if (clear_stats) begin
      a_stall_d = 16'd0;
      b_stall_d = 16'd0;
    end else begin
      if (a_valid && !a_ready && (a_stall_q != STALL_MAX)) a_stall_d = a_stall_q + 16'd1;
      if (b_valid && !b_ready && (b_stall_q != STALL_MAX)) b_stall_d = b_stall_q + 16'd1;
    end
  end

  // Reset also discards whatever grant was computed in the reset cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= GRANT_B;
      wr_reg_q     <= 5'd0;
      wr_data_q    <= 32'h0;
      a_stall_q    <= 16'd0;
      b_stall_q    <= 16'd0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      a_stall_q    <= a_stall_d;
      b_stall_q    <= b_stall_d;
    end
  end

  assign wr_reg      = wr_reg_q;
  assign wr_data     = wr_data_q;
  assign a_stall_cnt = a_stall_q;
  assign b_stall_cnt = b_stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model predicts ready and the
// write each cycle; predicted writes are queued and compared when the DUT emits them.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, clear_stats;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [15:0] a_stall_cnt, b_stall_cnt;

  regfile_wb_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .a_valid     (a_valid),
    .a_reg       (a_reg),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_reg       (b_reg),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .clear_stats (clear_stats),
    .a_stall_cnt (a_stall_cnt),
    .b_stall_cnt (b_stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic [15:0] sa;
    logic [15:0] sb;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Model state: who won last, last written data, stall counts.
  bit          mdl_b_won_last;
  logic [31:0] mdl_wd;
  logic [15:0] mdl_sa, mdl_sb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive, check ready mid-cycle, predict, then check registered outputs.
  task automatic cycle(input bit rst, input bit clr,
                       input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit bv, input logic [4:0] br, input logic [31:0] bd);
    bit   a_wants, b_wants, exp_ra, exp_rb;
    exp_t e, got;
    reset = rst; clear_stats = clr;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    #3;
    a_wants = av && (ar != 0);
    b_wants = bv && (br != 0);
    if (rst) begin
      exp_ra = 0; exp_rb = 0;
    end else if (a_wants && b_wants) begin
      exp_ra = mdl_b_won_last;
      exp_rb = !mdl_b_won_last;
    end else begin
      exp_ra = 1; exp_rb = 1;
    end
    chk("a_ready", {31'd0, a_ready}, {31'd0, exp_ra});
    chk("b_ready", {31'd0, b_ready}, {31'd0, exp_rb});

    if (rst) begin
      mdl_b_won_last = 1;
      mdl_wd = 32'h0;
      mdl_sa = 0; mdl_sb = 0;
      e.r = 0;
    end else begin
      e.r = 0;
      if (a_wants && exp_ra) begin
        e.r = ar; mdl_wd = ad; mdl_b_won_last = 0;
      end else if (b_wants && exp_rb) begin
        e.r = br; mdl_wd = bd; mdl_b_won_last = 1;
      end
      if (clr) begin
        mdl_sa = 0; mdl_sb = 0;
      end else begin
        if (av && !exp_ra && mdl_sa != 16'hFFFF) mdl_sa++;
        if (bv && !exp_rb && mdl_sb != 16'hFFFF) mdl_sb++;
      end
    end
    e.d = mdl_wd; e.sa = mdl_sa; e.sb = mdl_sb;
    exp_q.push_back(e);

    @(posedge clock); #1;
    got = exp_q.pop_front();
    chk("wr_reg", {27'd0, wr_reg}, {27'd0, got.r});
    chk("wr_data", wr_data, got.d);
    chk("a_stall_cnt", {16'd0, a_stall_cnt}, {16'd0, got.sa});
    chk("b_stall_cnt", {16'd0, b_stall_cnt}, {16'd0, got.sb});
    $display("t=%0t rst=%0b clr=%0b A(%0b,%0d,%h) B(%0b,%0d,%h) rdy=%0b%0b -> wr_reg=%0d wr_data=%h sa=%0d sb=%0d",
             $time, rst, clr, av, ar, ad, bv, br, bd, exp_ra, exp_rb,
             wr_reg, wr_data, a_stall_cnt, b_stall_cnt);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  initial begin
    reset = 1; clear_stats = 0;
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    mdl_b_won_last = 1; mdl_wd = 0; mdl_sa = 0; mdl_sb = 0;
    @(posedge clock); #1;

    // Reset state, with requests present so ready=0 and no counting is exercised.
    cycle(1, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Tie after reset: A wins first, B next, b_stall = 1.
    cycle(0, 0, 1, 5'd5, 32'hA5A5_0005, 1, 5'd6, 32'hB6B6_0006);
    cycle(0, 0, 1, 5'd5, 32'hA5A5_0005, 1, 5'd6, 32'hB6B6_0006);
    idle();

    // Null write on A never blocks B.
    cycle(0, 0, 1, 5'd0, 32'h1234_5678, 1, 5'd9, 32'hDEAD_BEEF);
    idle();

    // Back-to-back A-only writes, no bubbles.
    for (int i = 1; i <= 4; i++)
      cycle(0, 0, 1, 5'(i), 32'h1000_0000 + 32'(i), 0, 5'd0, 32'h0);
    idle();

    // A loses, then changes reg/data while stalled; only the accepted values land.
    cycle(0, 0, 1, 5'd10, 32'hAAAA_0010, 1, 5'd12, 32'hBBBB_0012);
    cycle(0, 0, 1, 5'd11, 32'hAAAA_0011, 1, 5'd13, 32'hBBBB_0013);
    idle();

    // Clear counters; a B-only write leaves B as last winner so A wins the next tie.
    cycle(0, 1, 0, 5'd0, 32'h0, 1, 5'd3, 32'h0000_0333);

    // Both ports hammer r7: strict alternation, 4 stalls each.
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 1, 5'd7, 32'hA000_0000 + 32'(i), 1, 5'd7, 32'hB000_0000 + 32'(i));
    idle();

    // Preload B's counter close to its limit, then keep B stalling past saturation.
    force dut.b_stall_q = 16'hFFFD;
    #1;
    release dut.b_stall_q;
    mdl_sb = 16'hFFFD;
    for (int i = 0; i < 7; i++)
      cycle(0, 0, 1, 5'd8, 32'hC000_0000 + 32'(i), 1, 5'd14, 32'hD000_0000 + 32'(i));
    cycle(0, 1, 1, 5'd8, 32'hC000_0100, 1, 5'd14, 32'hD000_0100);
    cycle(0, 0, 1, 5'd8, 32'hC000_0200, 1, 5'd14, 32'hD000_0200);
    idle();

    // Reset while A is live, right after a grant: the grant is dropped.
    cycle(0, 0, 1, 5'd20, 32'hE000_0020, 0, 5'd0, 32'h0);
    cycle(1, 0, 1, 5'd21, 32'hE000_0021, 0, 5'd0, 32'h0);
    // Requests held across reset release are arbitrated at once, A winning the tie.
    cycle(0, 0, 1, 5'd21, 32'hE000_0021, 1, 5'd22, 32'hF000_0022);
    cycle(0, 0, 0, 5'd0, 32'h0, 1, 5'd22, 32'hF000_0022);
    idle();

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
